life_gen_engine: RTL
====================

Name: life_gen_engine

Overview:
Parametrised next-generation engine for a Game of Life board of ROWS x COLS cells held in an external row-wide memory. On a start request it streams the board out one row per cycle and keeps a sliding three-row window plus a saved copy of original row 0. It writes each next-generation row back in place and pulses done. This generalises the fixed 8x8 toroidal B3/S23 row decoder to any board size, any birth/survive rule, and a selectable boundary mode.

Parameters:
COLS, 8, cells per row (>=3); also the memory data width
ROWS, 8, rows per board (>=3)
AW, $clog2(ROWS), row address width
BIRTH_MASK, 9'b000001000, bit n set -> dead cell with n live neighbours is born
SURVIVE_MASK, 9'b000001100, bit n set -> live cell with n live neighbours survives
WRAP, 1, 1 = toroidal edges; 0 = cells beyond the board edges are dead
GEN_W, 16, generation counter width

Ports:
clk  in  1  clock; all state on rising edge
reset  in  1  reset, synchronous, active-high
start  in  1  request one generation step; sampled only in IDLE
busy  out  1  step in progress
done  out  1  one-cycle pulse when the step completes
rd_en  out  1  memory read strobe
rd_addr  out  AW  memory read row
rd_data  in  COLS  read data, valid exactly 1 cycle after rd_en
wr_en  out  1  memory write strobe
wr_addr  out  AW  memory write row
wr_data  out  COLS  next-generation row
gen_count  out  GEN_W  completed generations
pop_count  out  $clog2(ROWS*COLS+1)  live cells in last generation (see optional feature)

Behaviour:
- Reset: busy=0, done=0, rd_en=0, wr_en=0, gen_count=0, pop_count=0, window and save registers=0, FSM in IDLE. A reset mid-step abandons the step; rows already written stay written.
- FSM states: IDLE -> RUN on start; RUN -> DONE after the last write; DONE -> IDLE after 1 cycle. start is ignored outside IDLE.
- Timing, with cycle 0 = the cycle start is sampled in IDLE:
  - busy=1 in cycles 1..ROWS+4.
  - rd_en=1 in cycles 1..ROWS+1, with addresses ROWS-1, 0, 1, ..., ROWS-1 in that order.
  - rd_data for row j is captured at the end of cycle j+3. Row 0 is also copied into the save register.
  - Row r (0..ROWS-1) is written in cycle r+5: wr_en=1, wr_addr=r.
  - Row ROWS-1 uses the saved original row 0 as its lower neighbour.
  - done=1 in cycle ROWS+5, with busy=0. gen_count increments in that same cycle and wraps modulo 2^GEN_W.
- Read/write ordering: the read address is always at least 3 rows ahead of the write address, so in-place update never corrupts an unread row. The memory must support a read and a write to different rows in the same cycle.
- Cell rule:
  - Neighbour count is 0..8 and uses 4-bit arithmetic; a count of 8 must not alias to 0.
  - next = center ? SURVIVE_MASK[n] : BIRTH_MASK[n].
- Edges:
  - WRAP=1: column 0 and column COLS-1 are neighbours; row 0 and row ROWS-1 are neighbours.
  - WRAP=0: the out-of-board column is treated as 0. The upper neighbour of row 0 and the lower neighbour of row ROWS-1 are treated as all-zero. The rd_en sequence is unchanged.
- Outputs are registered except wr_data, which is combinational from the window registers and is valid whenever wr_en=1.

Optional Feature:
LIFE_POPCOUNT_EN
- Defined:
  - A popcount of each written row accumulates into an internal accumulator, which clears at start acceptance.
  - pop_count loads the final sum in the done cycle and holds until the next done.
- Undefined: no accumulator logic; pop_count is tied to 0.

Test Plan:
1. 8x8 defaults, vertical blinker at rows 2-4 col 3, start -> done at cycle 13; memory holds row 3 = 8'b00011100, all other rows 0; gen_count=1. A second start restores the vertical blinker; gen_count=2.
2. 8x8 defaults, block at rows 0-1 cols 0-1 -> board unchanged after step. With LIFE_POPCOUNT_EN, pop_count=4.
3. 8x8 all ones: WRAP=1 -> all cells have n=8 and all die, board all zero. Also set SURVIVE_MASK bit 8 -> board stays all ones.
4. Glider crossing the row 7 / row 0 and col 7 / col 0 corner, 4 steps with WRAP=1 -> glider translated by (+1,+1) modulo 8. With WRAP=0, the same run matches a golden model with dead edges.
5. start held high during a step -> no restart; exactly ROWS+1 reads and ROWS writes per step; next step begins only after return to IDLE.
6. reset asserted in cycle 6 of a step -> next cycle busy=0, wr_en=0, rd_en=0, gen_count=0; a fresh start afterwards completes normally.

Source files
------------

// File: rtl/life_gen_engine.sv
// Game of Life next-generation engine: streams a ROWS x COLS board one row per cycle and
// writes each next-generation row back in place. Define LIFE_POPCOUNT_EN for population count.
module life_gen_engine #(
    parameter int unsigned COLS         = 8,
    parameter int unsigned ROWS         = 8,
    parameter int unsigned AW           = $clog2(ROWS),
    parameter logic [8:0]  BIRTH_MASK   = 9'b000001000,
    parameter logic [8:0]  SURVIVE_MASK = 9'b000001100,
    parameter bit          WRAP         = 1'b1,
    parameter int unsigned GEN_W        = 16
) (
    input  logic                             clk_i,
    input  logic                             reset_i,
    input  logic                             start_i,
    output logic                             busy_o,
    output logic                             done_o,
    output logic                             rd_en_o,
    output logic [AW-1:0]                    rd_addr_o,
    input  logic [COLS-1:0]                  rd_data_i,
    output logic                             wr_en_o,
    output logic [AW-1:0]                    wr_addr_o,
    output logic [COLS-1:0]                  wr_data_o,
    output logic [GEN_W-1:0]                 gen_count_o,
    output logic [$clog2(ROWS*COLS+1)-1:0]   pop_count_o
);

    localparam int unsigned PCW = $clog2(ROWS*COLS+1);
    localparam int unsigned CW  = $clog2(ROWS+6);
    // Masks widened so a 4-bit neighbour count can index them directly.
    localparam logic [15:0] BirthLut   = {7'b0, BIRTH_MASK};
    localparam logic [15:0] SurviveLut = {7'b0, SURVIVE_MASK};

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              rd_en_q, rd_en_d;
    logic [AW-1:0]     rd_addr_q, rd_addr_d;
    logic              wr_en_q, wr_en_d;
    logic [AW-1:0]     wr_addr_q, wr_addr_d;
    logic [COLS-1:0]   top_q, top_d, mid_q, mid_d, bot_q, bot_d;
    logic [COLS-1:0]   save_q, save_d;
    logic [GEN_W-1:0]  gen_q, gen_d;
    logic              start_acc;
    logic              last_cyc;

    assign start_acc = (state_q == StIdle) && start_i;
    assign last_cyc  = (state_q == StRun) && (cnt_q == CW'(ROWS + 4));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        rd_en_d   = 1'b0;
        rd_addr_d = rd_addr_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        top_d     = top_q;
        mid_d     = mid_q;
        bot_d     = bot_q;
        save_d    = save_q;
        gen_d     = gen_q;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d   = StRun;
                    cnt_d     = CW'(1);
                    busy_d    = 1'b1;
                    rd_en_d   = 1'b1;
                    rd_addr_d = AW'(ROWS - 1);
                    wr_addr_d = '0;
                end
            end
            StRun: begin
                cnt_d   = cnt_q + CW'(1);
                rd_en_d = (cnt_q <= CW'(ROWS));
                wr_en_d = (cnt_q >= CW'(4)) && (cnt_q <= CW'(ROWS + 3));
                if (rd_en_q) begin
                    rd_addr_d = (rd_addr_q == AW'(ROWS - 1)) ? '0 : rd_addr_q + AW'(1);
                end
                if (wr_en_q && (wr_addr_q != AW'(ROWS - 1))) begin
                    wr_addr_d = wr_addr_q + AW'(1);
                end
                // Window shifts in rows ROWS-1, 0..ROWS-1, then the saved original row 0.
                if ((cnt_q >= CW'(2)) && (cnt_q <= CW'(ROWS + 2))) begin
                    top_d = mid_q;
                    mid_d = bot_q;
                    bot_d = rd_data_i;
                end else if (cnt_q == CW'(ROWS + 3)) begin
                    top_d = mid_q;
                    mid_d = bot_q;
                    bot_d = save_q;
                end
                if (cnt_q == CW'(3)) begin
                    save_d = rd_data_i;
                end
                if (last_cyc) begin
                    state_d = StDone;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    gen_d   = gen_q + GEN_W'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            top_q     <= '0;
            mid_q     <= '0;
            bot_q     <= '0;
            save_q    <= '0;
            gen_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            rd_en_q   <= rd_en_d;
            rd_addr_q <= rd_addr_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            top_q     <= top_d;
            mid_q     <= mid_d;
            bot_q     <= bot_d;
            save_q    <= save_d;
            gen_q     <= gen_d;
        end
    end

    // Dead-edge mode blanks the neighbour row that falls off the board.
    logic [COLS-1:0] top_eff, bot_eff;
    assign top_eff = (!WRAP && (wr_addr_q == '0)) ? '0 : top_q;
    assign bot_eff = (!WRAP && (wr_addr_q == AW'(ROWS - 1))) ? '0 : bot_q;

    for (genvar c = 0; c < int'(COLS); c++) begin : g_cell
        localparam int Lc  = (c == 0) ? int'(COLS) - 1 : c - 1;
        localparam int Rc  = (c == int'(COLS) - 1) ? 0 : c + 1;
        localparam bit LOk = WRAP || (c != 0);
        localparam bit ROk = WRAP || (c != int'(COLS) - 1);
        logic [3:0] n;
        assign n = {3'b000, top_eff[Lc] & LOk} + {3'b000, top_eff[c]} +
                   {3'b000, top_eff[Rc] & ROk} + {3'b000, mid_q[Lc] & LOk} +
                   {3'b000, mid_q[Rc] & ROk}   + {3'b000, bot_eff[Lc] & LOk} +
                   {3'b000, bot_eff[c]}        + {3'b000, bot_eff[Rc] & ROk};
        assign wr_data_o[c] = mid_q[c] ? SurviveLut[n] : BirthLut[n];
    end

`ifdef LIFE_POPCOUNT_EN
    function automatic logic [PCW-1:0] row_pop(input logic [COLS-1:0] row);
        logic [PCW-1:0] s;
        s = '0;
        for (int i = 0; i < int'(COLS); i++) begin
            s = s + PCW'(row[i]);
        end
        return s;
    endfunction

    logic [PCW-1:0] acc_q, acc_d, pop_q, pop_d;

    always_comb begin
        acc_d = acc_q;
        pop_d = pop_q;
        if (start_acc) begin
            acc_d = '0;
        end else if (wr_en_q) begin
            acc_d = acc_q + row_pop(wr_data_o);
        end
        if (last_cyc) begin
            pop_d = acc_q + row_pop(wr_data_o);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            acc_q <= '0;
            pop_q <= '0;
        end else begin
            acc_q <= acc_d;
            pop_q <= pop_d;
        end
    end

    assign pop_count_o = pop_q;
`else
    assign pop_count_o = '0;
`endif

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign rd_en_o     = rd_en_q;
    assign rd_addr_o   = rd_addr_q;
    assign wr_en_o     = wr_en_q;
    assign wr_addr_o   = wr_addr_q;
    assign gen_count_o = gen_q;

endmodule
